dac_channel_sequencer: RTL and testbench

- Upstream feeder for the DAC7611 serial driver and its 6-way output mux.
- Holds one 12-bit code per mux channel and steps through the channels round-robin. For each channel it:
  - drives the one-hot mux select,
  - waits for the select to settle,
  - hands the 12-bit code to the serializer over a valid/ready handshake,
  - waits for the serializer's load-complete pulse,
  - dwells, then advances.
- Replaces hard-coded DAC data and mux timing with a programmable table.

---
 rtl/dac_pkg.sv | 36 +++
 rtl/dac_code_table.sv | 33 +++
 rtl/dac_channel_sequencer.sv | 148 ++++++++++++++
 tb/tb_dac_channel_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// dac_pkg
// Shared definitions for the DAC channel sequencer and the DAC7611 serializer:
// channel count, code width, FSM state encoding and default mux timing.
package dac_pkg;

    localparam int NUM_CH   = 6;
    localparam int DATA_W   = 12;
    localparam int CH_W     = 3;
    localparam int SETTLE_W = 8;
    localparam int DWELL_W  = 10;

    localparam int SETTLE_CYC_DEF = 8;
    localparam int DWELL_CYC_DEF  = 400;

    typedef logic [CH_W-1:0] ch_t;

    localparam ch_t LAST_CH = ch_t'(NUM_CH - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_BREAK     = 3'd1,
        ST_SELECT    = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_DWELL     = 3'd5
    } state_t;

    // Round-robin successor, wrapping the last channel back to 0.
    function automatic ch_t next_ch(input ch_t ch);
        if (ch == LAST_CH) begin
            return '0;
        end
        return ch_t'(ch + 1'b1);
    endfunction

endpackage

// File: rtl/dac_code_table.sv
// dac_code_table
// One DAC code per mux channel. Synchronous write, combinational read.
// Ports:
//   clk, reset        clock, async active-low reset (clears every entry)
//   we, waddr, wdata  write strobe/index/code; indices past the last channel are dropped
//   raddr, rdata      combinational read of the entry at raddr
module dac_code_table
    import dac_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [CH_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [CH_W-1:0]   raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [NUM_CH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr <= LAST_CH)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (raddr <= LAST_CH) ? mem[raddr] : '0;

endmodule

// File: rtl/dac_channel_sequencer.sv
// dac_channel_sequencer
// Steps round-robin through the DAC output mux channels. For each channel it
// drives the one-hot select, waits for it to settle, offers the stored code to
// the serializer over valid/ready, waits for load_done, dwells, then advances.
// Ports:
//   clk, reset                  clock, async active-low reset
//   enable                      run; when low, stop at the next channel boundary
//   cfg_we, cfg_addr, cfg_data  code table write port
//   sample_valid/data/ready     handshake toward the serializer
//   load_done                   one-cycle pulse from the serializer after LD
//   mux_signals                 one-hot mux select, zero when no channel active
//   ch_idx                      active channel
//   frame_pulse                 one cycle after the last channel finishes dwelling
//   busy                        FSM not idle
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | mux off, waiting for enable
// BREAK      | one cycle with mux off before selecting the next channel
// SELECT     | mux on, settle counter running
// SEND       | code offered, waiting for sample_ready
// WAIT_DONE  | code accepted, waiting for load_done
// DWELL      | mux held, dwell counter running, then advance channel
module dac_channel_sequencer
    import dac_pkg::*;
#(
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int DWELL_CYC  = DWELL_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              sample_valid,
    output logic [DATA_W-1:0] sample_data,
    input  logic              sample_ready,
    input  logic              load_done,
    output logic [NUM_CH-1:0] mux_signals,
    output logic [CH_W-1:0]   ch_idx,
    output logic              frame_pulse,
    output logic              busy
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [DWELL_W-1:0]  DWELL_LOAD  = DWELL_W'(DWELL_CYC - 1);

    state_t              state, state_next;
    logic [SETTLE_W-1:0] settle_cnt, settle_next;
    logic [DWELL_W-1:0]  dwell_cnt, dwell_next;
    logic [CH_W-1:0]     ch_next;
    logic                valid_next;
    logic [DATA_W-1:0]   data_next;
    logic                frame_next;
    logic [DATA_W-1:0]   table_data;

    dac_code_table u_table (
        .clk   (clk),
        .reset (reset),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (ch_idx),
        .rdata (table_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            settle_cnt   <= '0;
            dwell_cnt    <= '0;
            ch_idx       <= '0;
            sample_valid <= 1'b0;
            sample_data  <= '0;
            frame_pulse  <= 1'b0;
        end else begin
            state        <= state_next;
            settle_cnt   <= settle_next;
            dwell_cnt    <= dwell_next;
            ch_idx       <= ch_next;
            sample_valid <= valid_next;
            sample_data  <= data_next;
            frame_pulse  <= frame_next;
        end
    end

    always_comb begin
        state_next  = state;
        settle_next = settle_cnt;
        dwell_next  = dwell_cnt;
        ch_next     = ch_idx;
        valid_next  = sample_valid;
        data_next   = sample_data;
        frame_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_BREAK;
                end
            end
            ST_BREAK: begin
                state_next  = ST_SELECT;
                settle_next = SETTLE_LOAD;
            end
            ST_SELECT: begin
                // Code is captured here so later table writes cannot disturb
                // a transfer already in progress.
                if (settle_cnt == '0) begin
                    data_next  = table_data;
                    valid_next = 1'b1;
                    state_next = ST_SEND;
                end else begin
                    settle_next = settle_cnt - 1'b1;
                end
            end
            ST_SEND: begin
                if (sample_valid && sample_ready) begin
                    valid_next = 1'b0;
                    state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (load_done) begin
                    state_next = ST_DWELL;
                    dwell_next = DWELL_LOAD;
                end
            end
            ST_DWELL: begin
                if (dwell_cnt == '0) begin
                    frame_next = (ch_idx == LAST_CH);
                    ch_next    = next_ch(ch_idx);
                    state_next = enable ? ST_BREAK : ST_IDLE;
                end else begin
                    dwell_next = dwell_cnt - 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign mux_signals = (state inside {ST_SELECT, ST_SEND, ST_WAIT_DONE, ST_DWELL})
                         ? (NUM_CH'(1) << ch_idx) : '0;
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_dac_channel_sequencer.sv
// Directed bench for dac_channel_sequencer with a small serializer responder.
module tb_dac_channel_sequencer;
    import dac_pkg::*;

    typedef struct packed {
        logic [2:0]  ch;
        logic [11:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [11:0] cfg_data;
    logic        sample_valid;
    logic [11:0] sample_data;
    logic        sample_ready;
    logic        load_done;
    logic [5:0]  mux_signals;
    logic [2:0]  ch_idx;
    logic        frame_pulse;
    logic        busy;

    logic        ld_auto = 1'b0;
    logic        ld_man  = 1'b0;
    logic        auto_ld = 1'b1;
    logic        hs_seen = 1'b0;
    int          pend = 0;
    int          frame_cnt = 0;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [11:0] shadow [NUM_CH];

    assign load_done = ld_auto | ld_man;

    dac_channel_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .load_done    (load_done),
        .mux_signals  (mux_signals),
        .ch_idx       (ch_idx),
        .frame_pulse  (frame_pulse),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serializer stand-in: load_done three cycles after each accepted code.
    always @(posedge clk) hs_seen <= auto_ld & sample_valid & sample_ready;

    always @(negedge clk) begin
        if (!reset) begin
            pend    = 0;
            ld_auto = 1'b0;
        end else begin
            ld_auto = 1'b0;
            if (pend != 0) begin
                pend--;
                if (pend == 0) ld_auto = 1'b1;
            end
            if (hs_seen) pend = 2;
        end
    end

    always @(negedge clk) begin
        if (frame_pulse === 1'b1) frame_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] ch, input logic [11:0] d);
        exp_t e;
        e.ch   = ch;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic write_cfg(input logic [2:0] a, input logic [11:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        if (int'(a) < NUM_CH) shadow[a] = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Returns at the negedge just before the accepting clock edge.
    task automatic wait_hs(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (!(sample_valid && sample_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_handshake"}, 32'(sample_valid && sample_ready), 32'd1);
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_data"}, 32'(sample_data), 32'(e.data));
            check({tag, "_ch_idx"}, 32'(ch_idx), 32'(e.ch));
            check({tag, "_mux"}, 32'(mux_signals), 32'(6'b000001 << e.ch));
        end
    endtask

    initial begin : main
        int         cnt;
        int         sel;
        int         n;
        int         k;
        logic       sent;
        logic [5:0] first_mux;

        reset        = 1'b1;
        enable       = 1'b0;
        cfg_we       = 1'b0;
        cfg_addr     = '0;
        cfg_data     = '0;
        sample_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) shadow[i] = '0;
        #1 reset = 1'b0;
        #2;
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_data", 32'(sample_data), 32'd0);
        check("rst_mux", 32'(mux_signals), 32'd0);
        check("rst_ch_idx", 32'(ch_idx), 32'd0);
        check("rst_frame", 32'(frame_pulse), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        repeat (2) @(negedge clk);
        reset = 1'b1;
        write_cfg(3'd0, 12'h555);
        write_cfg(3'd1, 12'hAAA);
        write_cfg(3'd2, 12'h000);
        write_cfg(3'd3, 12'hFFF);
        write_cfg(3'd4, 12'h123);
        write_cfg(3'd5, 12'h800);
        write_cfg(3'd7, 12'hBAD);

        // Round 1, channel 0: enable-to-valid latency and break/select timing
        push_exp(3'd0, shadow[0]);
        enable = 1'b1;
        cnt = 0;
        sel = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                check("break_mux_off", 32'(mux_signals), 32'd0);
                check("break_busy", 32'(busy), 32'd1);
            end
            if (mux_signals != 0 && !sample_valid) sel++;
        end while (!sample_valid && cnt < 50);
        check("first_valid_latency", cnt, 32'd10);
        check("select_hold_cycles", sel, 32'd8);
        wait_hs("r1_ch0");
        @(negedge clk);

        // Channel 1: rewrite its entry while the code is being offered
        sample_ready = 1'b0;
        push_exp(3'd1, shadow[1]);
        n = 0;
        while (!sample_valid && n < 1000) begin @(negedge clk); n++; end
        check("ch1_in_send", 32'(sample_valid), 32'd1);
        write_cfg(3'd1, 12'h7FF);
        sample_ready = 1'b1;
        wait_hs("r1_ch1");
        @(negedge clk);

        // Channel 2: back-pressure for 20 cycles
        sample_ready = 1'b0;
        push_exp(3'd2, shadow[2]);
        n = 0;
        while (!sample_valid && n < 1000) begin @(negedge clk); n++; end
        for (int i = 0; i < 20; i++) begin
            check($sformatf("bp_valid_%0d", i), 32'(sample_valid), 32'd1);
            check($sformatf("bp_data_%0d", i), 32'(sample_data), 32'h000);
            @(negedge clk);
        end
        sample_ready = 1'b1;
        wait_hs("r1_ch2");
        @(negedge clk);
        check("bp_single_transfer", 32'(sample_valid), 32'd0);

        for (int c = 3; c < NUM_CH; c++) begin
            push_exp(3'(c), shadow[c]);
            wait_hs($sformatf("r1_ch%0d", c));
            if (c == NUM_CH - 1) check("frame_before_wrap", frame_cnt, 32'd0);
            @(negedge clk);
        end

        // Round 2: wrap to channel 0, channel 1 now carries the rewritten code
        for (int c = 0; c < 3; c++) begin
            push_exp(3'(c), shadow[c]);
            wait_hs($sformatf("r2_ch%0d", c));
            if (c == 0) check("frame_after_wrap", frame_cnt, 32'd1);
            @(negedge clk);
        end

        // Drop enable during channel 3 select
        n = 0;
        while (mux_signals != 6'b001000 && n < 1000) begin @(negedge clk); n++; end
        check("ch3_select", 32'(mux_signals), 32'h08);
        enable = 1'b0;
        push_exp(3'd3, shadow[3]);
        wait_hs("r2_ch3");
        k = 0;
        while (busy && k < 1000) begin @(negedge clk); k++; end
        check("stop_hs_to_idle_cycles", k, 32'd404);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_mux", 32'(mux_signals), 32'd0);
        check("stop_ch_idx", 32'(ch_idx), 32'd4);
        check("stop_frame_cnt", frame_cnt, 32'd1);
        repeat (5) @(negedge clk);
        check("idle_stays", 32'(busy), 32'd0);

        // Re-enable resumes at channel 4
        enable = 1'b1;
        push_exp(3'd4, shadow[4]);
        n = 0;
        while (mux_signals == 0 && n < 50) begin @(negedge clk); n++; end
        check("resume_mux", 32'(mux_signals), 32'h10);
        check("resume_latency", n, 32'd2);
        wait_hs("r2_ch4");

        // Asynchronous reset while waiting for load_done
        @(negedge clk);
        check("wd_valid", 32'(sample_valid), 32'd0);
        check("wd_mux", 32'(mux_signals), 32'h10);
        #1 reset = 1'b0;
        #1;
        check("arst_valid", 32'(sample_valid), 32'd0);
        check("arst_data", 32'(sample_data), 32'd0);
        check("arst_mux", 32'(mux_signals), 32'd0);
        check("arst_ch_idx", 32'(ch_idx), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_frame", 32'(frame_pulse), 32'd0);
        auto_ld = 1'b0;
        for (int i = 0; i < NUM_CH; i++) shadow[i] = '0;
        @(negedge clk);
        reset = 1'b1;

        // Restart at channel 0 with a cleared table; load_done during SELECT
        // and in the handshake cycle must both be ignored
        push_exp(3'd0, shadow[0]);
        cnt = 0;
        sent = 1'b0;
        first_mux = '0;
        do begin
            @(negedge clk);
            ld_man = 1'b0;
            cnt++;
            if (mux_signals != 0 && !sent) begin
                ld_man    = 1'b1;
                sent      = 1'b1;
                first_mux = mux_signals;
            end
        end while (!sample_valid && cnt < 50);
        check("restart_first_mux", 32'(first_mux), 32'h01);
        check("restart_latency", cnt, 32'd10);
        ld_man = 1'b1;
        wait_hs("rst_ch0");
        @(negedge clk);
        ld_man = 1'b0;
        repeat (10) @(negedge clk);
        check("ignored_done_ch_idx", 32'(ch_idx), 32'd0);
        check("ignored_done_busy", 32'(busy), 32'd1);
        ld_man = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            ld_man = 1'b0;
            k++;
        end while (ch_idx == 0 && k < 1000);
        check("done_to_advance_cycles", k, 32'd401);
        check("advance_ch_idx", 32'(ch_idx), 32'd1);
        check("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
